data_mem_ctrl: RTL and testbench

//  Parametrised, clocked data memory for the load/store path of the CPU datapath.

---
 rtl/data_mem_pkg.sv | 28 ++
 rtl/data_mem_byte_array.sv | 35 +++
 rtl/data_mem_ctrl.sv | 179 +++++++++++++++++
 tb/tb_data_mem_ctrl.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_mem_pkg.sv
// Shared definitions for the data memory controller: access sizes, FSM states
// and the alignment rule used by the controller.
package data_mem_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;
    localparam logic [1:0] SIZE_ILL  = 2'b11;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        ACCESS = 2'd2
    } state_e;

    // True when the access must be refused: half needs A[0]=0, word needs A[1:0]=00.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] a);
        logic bad;
        case (size)
            SIZE_BYTE: bad = 1'b0;
            SIZE_HALF: bad = a[0];
            SIZE_WORD: bad = (a != 2'b00);
            default:   bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/data_mem_byte_array.sv
// DEPTH x 8 byte array with a 4-byte big-endian window at addr_i..addr_i+3.
// Lane 3 (bits 31:24) is the byte at addr_i; writes are synchronous, reads combinational.
module mem_byte_array #(
    parameter int DEPTH  = 512,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic [3:0]        we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [31:0]       wdata_i,
    output logic [31:0]       rdata_o
);

    logic [7:0]        mem_q     [DEPTH];
    logic [ADDR_W-1:0] lane_addr [4];

    // Window addresses wrap naturally; only unused lanes of a byte/half access can wrap.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            lane_addr[i] = addr_i + ADDR_W'(i);
        end
    end

    always_ff @(posedge clk_i) begin
        for (int i = 0; i < 4; i++) begin
            if (we_i[3-i]) begin
                mem_q[lane_addr[i]] <= wdata_i[8*(3-i) +: 8];
            end
        end
    end

    assign rdata_o = {mem_q[lane_addr[0]], mem_q[lane_addr[1]],
                      mem_q[lane_addr[2]], mem_q[lane_addr[3]]};

endmodule

// File: rtl/data_mem_ctrl.sv
// Clocked big-endian data memory with req/resp handshake, programmable wait
// states, misalignment detection and optional sign extension on loads.
module data_mem_ctrl
    import data_mem_pkg::*;
#(
    parameter int    DEPTH     = 512,
    parameter int    ADDR_W    = $clog2(DEPTH),
    parameter int    LATENCY   = 1,
    parameter string INIT_FILE = ""
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] A,
    input  logic [31:0]       DI,
    input  logic [1:0]        Size,
    input  logic              RW,
    input  logic              SE,
    output logic              resp_valid,
    output logic [31:0]       DO,
    output logic              err,
    output state_e            dbg_state
);

    localparam logic [3:0] CNT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;
    localparam state_e     FIRST_ST = (LATENCY > 0) ? WAIT : ACCESS;

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] a_q, a_d;
    logic [31:0]       di_q, di_d;
    logic [1:0]        size_q, size_d;
    logic              rw_q, rw_d;
    logic              se_q, se_d;
    logic [31:0]       do_q, do_d;
    logic              err_q, err_d;
    logic              resp_q, resp_d;

    logic [3:0]        lane_we;
    logic [3:0]        mem_we;
    logic [3:0]        store_lanes;
    logic [31:0]       store_data;
    logic [31:0]       rdata;
    logic [31:0]       load_data;
    logic              bad_access;

    // The image named by INIT_FILE is applied by the implementation flow, not by this logic.
    logic unused_init_image;
    assign unused_init_image = (INIT_FILE != "");

    assign bad_access = is_misaligned(size_q, a_q[1:0]);

    // Right-justified store data is moved up so the MSB byte lands at address A.
    always_comb begin
        store_lanes = 4'b0000;
        store_data  = di_q;
        case (size_q)
            SIZE_BYTE: begin
                store_lanes = 4'b1000;
                store_data  = {di_q[7:0], 24'h0};
            end
            SIZE_HALF: begin
                store_lanes = 4'b1100;
                store_data  = {di_q[15:0], 16'h0};
            end
            SIZE_WORD: begin
                store_lanes = 4'b1111;
                store_data  = di_q;
            end
            default: begin
                store_lanes = 4'b0000;
                store_data  = di_q;
            end
        endcase
    end

    always_comb begin
        load_data = rdata;
        case (size_q)
            SIZE_BYTE: load_data = {{24{se_q & rdata[31]}}, rdata[31:24]};
            SIZE_HALF: load_data = {{16{se_q & rdata[31]}}, rdata[31:16]};
            default:   load_data = rdata;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        di_d    = di_q;
        size_d  = size_q;
        rw_d    = rw_q;
        se_d    = se_q;
        do_d    = do_q;
        err_d   = 1'b0;
        resp_d  = 1'b0;
        lane_we = 4'b0000;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    a_d     = A;
                    di_d    = DI;
                    size_d  = Size;
                    rw_d    = RW;
                    se_d    = SE;
                    cnt_d   = CNT_INIT;
                    state_d = FIRST_ST;
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = ACCESS;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ACCESS: begin
                state_d = IDLE;
                resp_d  = 1'b1;
                if (bad_access) begin
                    err_d = 1'b1;
                end else if (rw_q) begin
                    lane_we = store_lanes;
                end else begin
                    do_d = load_data;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            a_q     <= '0;
            di_q    <= 32'h0;
            size_q  <= SIZE_BYTE;
            rw_q    <= 1'b0;
            se_q    <= 1'b0;
            do_q    <= 32'h0;
            err_q   <= 1'b0;
            resp_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            di_q    <= di_d;
            size_q  <= size_d;
            rw_q    <= rw_d;
            se_q    <= se_d;
            do_q    <= do_d;
            err_q   <= err_d;
            resp_q  <= resp_d;
        end
    end

    // A store whose ACCESS edge coincides with reset is dropped.
    assign mem_we = rst ? 4'b0000 : lane_we;

    mem_byte_array #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk_i   (clk),
        .we_i    (mem_we),
        .addr_i  (a_q),
        .wdata_i (store_data),
        .rdata_o (rdata)
    );

    assign req_ready  = (state_q == IDLE);
    assign resp_valid = resp_q;
    assign DO         = do_q;
    assign err        = err_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Randomized and directed bench for data_mem_ctrl: two instances (512 B / latency 1
// and 1024 B / latency 3), each tracked by a transaction-level reference model.
module tb_data_mem_ctrl;
    import data_mem_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]        rst_s;
    logic [1:0]        req_valid_s;
    logic [1:0]        req_ready_s;
    logic [1:0][9:0]   a_s;
    logic [1:0][31:0]  di_s;
    logic [1:0][1:0]   size_s;
    logic [1:0]        rw_s;
    logic [1:0]        se_s;
    logic [1:0]        resp_s;
    logic [1:0][31:0]  do_s;
    logic [1:0]        err_s;
    logic [1:0][1:0]   dbg_s;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_inst
        localparam int LAT = (g == 0) ? 1 : 3;
        localparam int DEP = (g == 0) ? 512 : 1024;
        localparam int AW  = $clog2(DEP);

        data_mem_ctrl #(
            .DEPTH   (DEP),
            .LATENCY (LAT)
        ) u_dut (
            .clk        (clk),
            .rst        (rst_s[g]),
            .req_valid  (req_valid_s[g]),
            .req_ready  (req_ready_s[g]),
            .A          (a_s[g][AW-1:0]),
            .DI         (di_s[g]),
            .Size       (size_s[g]),
            .RW         (rw_s[g]),
            .SE         (se_s[g]),
            .resp_valid (resp_s[g]),
            .DO         (do_s[g]),
            .err        (err_s[g]),
            .dbg_state  (dbg_s[g])
        );

        // Reference model: one outstanding transaction, completed LAT+1 edges after accept.
        logic [7:0]    mdl [DEP];
        logic          pend = 1'b0;
        int            cyc = 0;
        int            due = 0;
        logic [AW-1:0] pa;
        logic [31:0]   pdi;
        logic [1:0]    psz;
        logic          prw, pse;
        logic          exp_resp = 1'b0;
        logic          exp_err = 1'b0;
        logic [31:0]   exp_do = 32'h0;
        int            nb;
        logic [31:0]   v;
        logic [AW-1:0] ai;
        logic          bad_al;

        initial begin
            forever begin
                @(posedge clk);
                cyc++;
                if (rst_s[g]) begin
                    pend     = 1'b0;
                    exp_resp = 1'b0;
                    exp_err  = 1'b0;
                    exp_do   = 32'h0;
                end else begin
                    exp_resp = 1'b0;
                    exp_err  = 1'b0;
                    if (pend && cyc == due) begin
                        pend     = 1'b0;
                        exp_resp = 1'b1;
                        bad_al   = (psz == 2'd3) || (psz == 2'd1 && pa[0]) ||
                                   (psz == 2'd2 && pa[1:0] != 2'b00);
                        nb       = 1 << psz;
                        if (bad_al) begin
                            exp_err = 1'b1;
                        end else if (prw) begin
                            for (int i = 0; i < nb; i++) begin
                                ai = pa + AW'(i);
                                mdl[ai] = pdi[8*(nb-1-i) +: 8];
                            end
                        end else begin
                            v = 32'h0;
                            for (int i = 0; i < nb; i++) begin
                                ai = pa + AW'(i);
                                v = (v << 8) | {24'h0, mdl[ai]};
                            end
                            if (pse && nb == 1 && v[7])  v = v | 32'hFFFF_FF00;
                            if (pse && nb == 2 && v[15]) v = v | 32'hFFFF_0000;
                            exp_do = v;
                        end
                    end else if (!pend && req_valid_s[g]) begin
                        pend = 1'b1;
                        due  = cyc + LAT + 1;
                        pa   = a_s[g][AW-1:0];
                        pdi  = di_s[g];
                        psz  = size_s[g];
                        prw  = rw_s[g];
                        pse  = se_s[g];
                    end
                end
            end
        end

        initial begin
            @(posedge clk);
            forever begin
                @(negedge clk);
                check($sformatf("i%0d_resp_valid", g), 32'(resp_s[g]), 32'(exp_resp));
                check($sformatf("i%0d_err", g), 32'(err_s[g]), 32'(exp_err));
                check($sformatf("i%0d_DO", g), do_s[g], exp_do);
                check($sformatf("i%0d_req_ready", g), 32'(req_ready_s[g]), 32'(!pend));
                check($sformatf("i%0d_state_idle", g), 32'(dbg_s[g] == IDLE), 32'(!pend));
            end
        end
    end

    logic [31:0] r_do;
    logic        r_err;
    int          r_lat;

    // One complete request/response; returns DO, err and the edges from accept to resp.
    task automatic xact(input int k, input string name, input logic [9:0] a, input logic [31:0] di,
                        input logic [1:0] sz, input logic rw, input logic se,
                        output logic [31:0] dout, output logic e, output int lat);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!req_ready_s[k] && guard < 64) begin
            @(negedge clk);
            guard++;
        end
        check({name, "_ready"}, 32'(req_ready_s[k]), 32'd1);
        a_s[k]         = a;
        di_s[k]        = di;
        size_s[k]      = sz;
        rw_s[k]        = rw;
        se_s[k]        = se;
        req_valid_s[k] = 1'b1;
        @(negedge clk);
        req_valid_s[k] = 1'b0;
        lat = 0;
        while (!resp_s[k] && lat < 64) begin
            @(negedge clk);
            lat++;
        end
        check({name, "_resp"}, 32'(resp_s[k]), 32'd1);
        dout = do_s[k];
        e    = err_s[k];
    endtask

    // Starts a word store, then resets extra cycles after entering WAIT.
    task automatic abort_store(input int k, input string name, input int extra,
                               input logic [9:0] a, input logic [31:0] di);
        int seen;
        int guard;
        guard = 0;
        @(negedge clk);
        while (!req_ready_s[k] && guard < 64) begin
            @(negedge clk);
            guard++;
        end
        a_s[k]         = a;
        di_s[k]        = di;
        size_s[k]      = SIZE_WORD;
        rw_s[k]        = 1'b1;
        se_s[k]        = 1'b0;
        req_valid_s[k] = 1'b1;
        @(negedge clk);
        req_valid_s[k] = 1'b0;
        repeat (extra) @(negedge clk);
        rst_s[k] = 1'b1;
        @(negedge clk);
        rst_s[k] = 1'b0;
        check({name, "_state"}, 32'(dbg_s[k]), 32'(IDLE));
        check({name, "_ready"}, 32'(req_ready_s[k]), 32'd1);
        seen = int'(resp_s[k]);
        repeat (4) begin
            @(negedge clk);
            seen += int'(resp_s[k]);
        end
        check({name, "_no_resp"}, 32'(seen), 32'd0);
    endtask

    initial begin
        int low_run;
        int last_pulse;
        logic [1:0] sz;
        logic [9:0] ad;

        rst_s       = 2'b11;
        req_valid_s = 2'b00;
        a_s         = '0;
        di_s        = '0;
        size_s      = '0;
        rw_s        = 2'b00;
        se_s        = 2'b00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready", 32'(req_ready_s[0]), 32'd1);
        check("rst_resp", 32'(resp_s[0]), 32'd0);
        check("rst_DO", do_s[0], 32'h0);
        check("rst_err", 32'(err_s[0]), 32'd0);
        check("rst_state", 32'(dbg_s[0]), 32'(IDLE));
        rst_s = 2'b00;

        // Instance 0: 512 bytes, one wait state.
        for (int i = 0; i < 128; i++) begin
            xact(0, "fill0", 10'(i * 4), $urandom, SIZE_WORD, 1'b1, 1'b0, r_do, r_err, r_lat);
        end

        xact(0, "t1_st", 10'h010, 32'hDEAD_BEEF, SIZE_WORD, 1'b1, 1'b0, r_do, r_err, r_lat);
        check("t1_st_err", 32'(r_err), 32'd0);
        check("t1_st_lat", 32'(r_lat), 32'd2);
        xact(0, "t1_ld", 10'h010, 32'h0, SIZE_WORD, 1'b0, 1'b0, r_do, r_err, r_lat);
        check("t1_ld_DO", r_do, 32'hDEAD_BEEF);
        check("t1_ld_err", 32'(r_err), 32'd0);
        check("t1_ld_lat", 32'(r_lat), 32'd2);

        xact(0, "t2_b_se", 10'h011, 32'h0, SIZE_BYTE, 1'b0, 1'b1, r_do, r_err, r_lat);
        check("t2_b_se_DO", r_do, 32'hFFFF_FFAD);
        xact(0, "t2_b_ze", 10'h011, 32'h0, SIZE_BYTE, 1'b0, 1'b0, r_do, r_err, r_lat);
        check("t2_b_ze_DO", r_do, 32'h0000_00AD);
        xact(0, "t2_h_se", 10'h012, 32'h0, SIZE_HALF, 1'b0, 1'b1, r_do, r_err, r_lat);
        check("t2_h_se_DO", r_do, 32'hFFFF_BEEF);
        xact(0, "t2_h_ze", 10'h010, 32'h0, SIZE_HALF, 1'b0, 1'b0, r_do, r_err, r_lat);
        check("t2_h_ze_DO", r_do, 32'h0000_DEAD);
        xact(0, "t2_w_se", 10'h010, 32'h0, SIZE_WORD, 1'b0, 1'b1, r_do, r_err, r_lat);
        check("t2_w_se_DO", r_do, 32'hDEAD_BEEF);

        xact(0, "t3_st", 10'h020, 32'h1122_3344, SIZE_WORD, 1'b1, 1'b0, r_do, r_err, r_lat);
        xact(0, "t3_ld0", 10'h020, 32'h0, SIZE_WORD, 1'b0, 1'b0, r_do, r_err, r_lat);
        check("t3_ld0_DO", r_do, 32'h1122_3344);
        xact(0, "t3_mis", 10'h021, 32'h0000_AAAA, SIZE_HALF, 1'b1, 1'b0, r_do, r_err, r_lat);
        check("t3_mis_err", 32'(r_err), 32'd1);
        check("t3_mis_DO", r_do, 32'h1122_3344);
        check("t3_mis_lat", 32'(r_lat), 32'd2);
        xact(0, "t3_ld1", 10'h020, 32'h0, SIZE_WORD, 1'b0, 1'b0, r_do, r_err, r_lat);
        check("t3_ld1_DO", r_do, 32'h1122_3344);
        check("t3_ld1_err", 32'(r_err), 32'd0);
        xact(0, "t3_ill", 10'h000, 32'h0, SIZE_ILL, 1'b0, 1'b0, r_do, r_err, r_lat);
        check("t3_ill_err", 32'(r_err), 32'd1);
        check("t3_ill_DO", r_do, 32'h1122_3344);

        xact(0, "t5_st", 10'h1FC, 32'hCAFE_F00D, SIZE_WORD, 1'b1, 1'b0, r_do, r_err, r_lat);
        abort_store(0, "t5_wait", 0, 10'h1FC, 32'h1234_5678);
        xact(0, "t5_ld0", 10'h1FC, 32'h0, SIZE_WORD, 1'b0, 1'b0, r_do, r_err, r_lat);
        check("t5_ld0_DO", r_do, 32'hCAFE_F00D);
        abort_store(0, "t5_acc", 1, 10'h1FC, 32'h1234_5678);
        xact(0, "t5_ld1", 10'h1FC, 32'h0, SIZE_WORD, 1'b0, 1'b0, r_do, r_err, r_lat);
        check("t5_ld1_DO", r_do, 32'hCAFE_F00D);

        for (int i = 0; i < 200; i++) begin
            sz = 2'($urandom_range(0, 3));
            ad = 10'($urandom_range(0, 511));
            if ($urandom_range(0, 3) != 0) ad = ad & ~10'(3);
            xact(0, "rnd0", ad, $urandom, sz, 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), r_do, r_err, r_lat);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        // Instance 1: 1024 bytes, three wait states.
        for (int i = 0; i < 256; i++) begin
            xact(1, "fill1", 10'(i * 4), $urandom, SIZE_WORD, 1'b1, 1'b0, r_do, r_err, r_lat);
        end

        low_run    = 0;
        last_pulse = -1;
        @(negedge clk);
        req_valid_s[1] = 1'b1;
        for (int c = 0; c < 80; c++) begin
            sz = 2'($urandom_range(0, 3));
            ad = 10'($urandom);
            if ($urandom_range(0, 3) != 0) ad = ad & ~10'(3);
            a_s[1]    = ad;
            size_s[1] = sz;
            di_s[1]   = $urandom;
            rw_s[1]   = 1'($urandom_range(0, 1));
            se_s[1]   = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (!req_ready_s[1]) begin
                low_run++;
            end else begin
                if (low_run != 0) check("t4_ready_low", 32'(low_run), 32'd4);
                low_run = 0;
            end
            if (resp_s[1]) begin
                if (last_pulse >= 0) check("t4_resp_gap", 32'(c - last_pulse), 32'd5);
                last_pulse = c;
            end
        end
        req_valid_s[1] = 1'b0;

        xact(1, "t6_st", 10'h3FF, 32'h0000_005A, SIZE_BYTE, 1'b1, 1'b0, r_do, r_err, r_lat);
        check("t6_st_err", 32'(r_err), 32'd0);
        check("t6_st_lat", 32'(r_lat), 32'd4);
        xact(1, "t6_ld", 10'h3FF, 32'h0, SIZE_BYTE, 1'b0, 1'b0, r_do, r_err, r_lat);
        check("t6_ld_DO", r_do, 32'h0000_005A);
        check("t6_ld_err", 32'(r_err), 32'd0);
        xact(1, "t6_h", 10'h3FE, 32'h0000_8001, SIZE_HALF, 1'b1, 1'b0, r_do, r_err, r_lat);
        xact(1, "t6_hl", 10'h3FE, 32'h0, SIZE_HALF, 1'b0, 1'b1, r_do, r_err, r_lat);
        check("t6_hl_DO", r_do, 32'hFFFF_8001);

        for (int i = 0; i < 60; i++) begin
            sz = 2'($urandom_range(0, 3));
            ad = 10'($urandom);
            if ($urandom_range(0, 3) != 0) ad = ad & ~10'(3);
            xact(1, "rnd1", ad, $urandom, sz, 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), r_do, r_err, r_lat);
        end

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
